// File: rtl/register_file_pkg.sv
// Shared definitions for the general-purpose register file and the datapath.
package register_file_pkg;

    localparam int unsigned WORD_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS       = 2 ** REG_ADDR_WIDTH;
    localparam int unsigned REG_ZERO       = 0;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [WORD_WIDTH-1:0]     word_t;

    // True when the index names the hardwired zero register.
    function automatic logic is_zero_reg(input reg_addr_t idx);
        return idx == reg_addr_t'(REG_ZERO);
    endfunction

endpackage

// File: rtl/gprf_read_port.sv
// Combinational read-port mux; index 0 always returns zero.
module gprf_read_port
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
    input  logic [ADDR_WIDTH-1:0]                      address,
    output logic [DATA_WIDTH-1:0]                      data
);

    // Select the addressed entry, forcing zero for the zero register.
    always_comb begin
        data = '0;
        if (address != '0) begin
            data = regs[address];
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x 32 general-purpose register file: two combinational reads, one
// synchronous write, register 0 hardwired to zero.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address_A,
    input  logic [ADDR_WIDTH-1:0] address_B,
    input  logic [ADDR_WIDTH-1:0] address_W,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] reg_A,
    output logic [DATA_WIDTH-1:0] reg_B
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    // Register 0 has no storage; only entries 1..Depth-1 are flops.
    logic [DATA_WIDTH-1:0]                 regs_q [1:Depth-1];
    logic [Depth-1:0]                      wr_sel;
    logic [Depth-1:0][DATA_WIDTH-1:0]      regs_view;

    // One-hot write select; writes to register 0 are dropped here.
    always_comb begin
        wr_sel = '0;
        if (write_enable && (address_W != '0)) begin
            wr_sel[address_W] = 1'b1;
        end
    end

    // Storage: async clear has priority, so writes during reset are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < Depth; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= write_data;
                end
            end
        end
    end

    // Packed view of the file with a constant zero in slot 0.
    always_comb begin
        regs_view    = '0;
        for (int i = 1; i < Depth; i++) begin
            regs_view[i] = regs_q[i];
        end
    end

    gprf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_a (
        .regs    (regs_view),
        .address (address_A),
        .data    (reg_A)
    );

    gprf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_b (
        .regs    (regs_view),
        .address (address_B),
        .data    (reg_B)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;
    import register_file_pkg::*;

    logic      clk;
    logic      rst;
    reg_addr_t address_A;
    reg_addr_t address_B;
    reg_addr_t address_W;
    word_t     write_data;
    logic      write_enable;
    word_t     reg_A;
    word_t     reg_B;

    int tests_run;
    int tests_failed;

    register_file #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .address_A    (address_A),
        .address_B    (address_B),
        .address_W    (address_W),
        .write_data   (write_data),
        .write_enable (write_enable),
        .reg_A        (reg_A),
        .reg_B        (reg_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a write at the falling edge, let it land on the next rising edge.
    task automatic do_write(input reg_addr_t a, input word_t d);
        @(negedge clk);
        address_W    = a;
        write_data   = d;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        write_enable = 1'b0;
        address_A    = '0;
        address_B    = '0;
        address_W    = '0;
        write_data   = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            address_A = reg_addr_t'(i);
            address_B = reg_addr_t'(31 - i);
            #1;
            tests_run++;
            if (reg_A !== 32'h0000_0000) begin
                tests_failed++;
                $display("FAIL reset_A[%0d] got %h want 00000000", i, reg_A);
            end
            tests_run++;
            if (reg_B !== 32'h0000_0000) begin
                tests_failed++;
                $display("FAIL reset_B[%0d] got %h want 00000000", 31 - i, reg_B);
            end
        end
    endtask

    task automatic test_basic();
        do_write(5'd5, 32'hDEAD_BEEF);
        address_A = 5'd5;
        address_B = 5'd6;
        #1;
        tests_run++;
        if (reg_A !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL basic_A got %h want deadbeef", reg_A);
        end
        tests_run++;
        if (reg_B !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL basic_B got %h want 00000000", reg_B);
        end
    endtask

    task automatic test_zero_reg();
        do_write(5'd0, 32'h1234_5678);
        address_A = 5'd0;
        address_B = 5'd0;
        #1;
        tests_run++;
        if (reg_A !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL zero_A got %h want 00000000", reg_A);
        end
        tests_run++;
        if (reg_B !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL zero_B got %h want 00000000", reg_B);
        end
    endtask

    task automatic test_we_gating();
        do_write(5'd7, 32'd100);
        @(negedge clk);
        address_W    = 5'd7;
        write_data   = 32'd999;
        write_enable = 1'b0;
        address_A    = 5'd7;
        @(posedge clk);
        #1;
        tests_run++;
        if (reg_A !== 32'd100) begin
            tests_failed++;
            $display("FAIL we_gating got %0d want 100", reg_A);
        end
    endtask

    task automatic test_dual_overwrite();
        do_write(5'd31, 32'hFFFF_FFFF);
        do_write(5'd1, 32'd42);
        address_A = 5'd31;
        address_B = 5'd1;
        #1;
        tests_run++;
        if (reg_A !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL dual_A got %h want ffffffff", reg_A);
        end
        tests_run++;
        if (reg_B !== 32'd42) begin
            tests_failed++;
            $display("FAIL dual_B got %0d want 42", reg_B);
        end
        // Read-during-write: old value before the edge, new value after.
        @(negedge clk);
        address_W    = 5'd1;
        write_data   = 32'd43;
        write_enable = 1'b1;
        address_A    = 5'd1;
        address_B    = 5'd1;
        #1;
        tests_run++;
        if (reg_A !== 32'd42) begin
            tests_failed++;
            $display("FAIL rdw_pre_A got %0d want 42", reg_A);
        end
        tests_run++;
        if (reg_B !== 32'd42) begin
            tests_failed++;
            $display("FAIL rdw_pre_B got %0d want 42", reg_B);
        end
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        tests_run++;
        if (reg_A !== 32'd43) begin
            tests_failed++;
            $display("FAIL rdw_post_A got %0d want 43", reg_A);
        end
        tests_run++;
        if (reg_B !== 32'd43) begin
            tests_failed++;
            $display("FAIL rdw_post_B got %0d want 43", reg_B);
        end
    endtask

    task automatic test_reset_mid();
        do_write(5'd10, 32'd77);
        address_A = 5'd10;
        address_B = 5'd5;
        #1;
        tests_run++;
        if (reg_A !== 32'd77) begin
            tests_failed++;
            $display("FAIL mid_pre got %0d want 77", reg_A);
        end
        // Assert reset between edges and check the clear is immediate.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (reg_A !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL mid_async_A got %h want 00000000", reg_A);
        end
        tests_run++;
        if (reg_B !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL mid_async_B got %h want 00000000", reg_B);
        end
        address_W    = 5'd10;
        write_data   = 32'd55;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (reg_A !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL mid_write_in_reset got %h want 00000000", reg_A);
        end
        @(negedge clk);
        write_enable = 1'b0;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (reg_A !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL mid_after_release got %h want 00000000", reg_A);
        end
        // First write after release lands normally.
        do_write(5'd10, 32'd88);
        tests_run++;
        if (reg_A !== 32'd88) begin
            tests_failed++;
            $display("FAIL mid_first_write got %0d want 88", reg_A);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_zero_reg();
        test_we_gating();
        test_dual_overwrite();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Two combinational read ports (A, B) feed the ALU operand paths. One synchronous write port is driven by the writeback stage.
- Register $0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, address width. Depth is 2**ADDR_WIDTH = 32 registers.

Ports:
- clk  input  1  single system clock; all writes occur on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears all registers.
- address_A  input  ADDR_WIDTH  read port A register index.
- address_B  input  ADDR_WIDTH  read port B register index.
- address_W  input  ADDR_WIDTH  write port register index.
- write_data  input  DATA_WIDTH  value to write.
- write_enable  input  1  active-high write strobe, sampled at the rising edge of clk.
- reg_A  output  DATA_WIDTH  contents of register address_A.
- reg_B  output  DATA_WIDTH  contents of register address_B.

Behaviour:
- Storage: 32 registers of DATA_WIDTH bits each.
- Reset:
  - rst low clears every register to 0 immediately, independent of clk.
  - While rst is low, reg_A and reg_B read 0 and writes are ignored.
  - Release of rst is synchronous-safe: the first write takes effect on the first rising edge after rst is high.
- Write:
  - On a rising edge of clk with rst high and write_enable = 1, regs[address_W] <= write_data.
  - write_enable = 0 leaves all registers unchanged.
- Register 0:
  - Writes with address_W = 0 are discarded.
  - Reads of address 0 always return 0 on both ports, regardless of any prior write attempt.
- Read:
  - Purely combinational, zero latency: reg_A = regs[address_A] and reg_B = regs[address_B].
  - Outputs update within the same delta cycle as an address change.
- Read-during-write:
  - No internal bypass. Before the write edge, a read of address_W returns the old value.
  - Immediately after the edge, it returns write_data.
- Both read ports may address the same register, including the register being written, simultaneously.
- Registers hold their value indefinitely absent reset or an enabled write.
- No X propagation from reset: all storage is defined from the first reset onward.

Decomposition:
- Shared package holds:
  - the REG_ZERO index constant (0);
  - NUM_REGS (32);
  - a reg_addr_t typedef (5 bits);
  - a word_t typedef (32 bits), shared with the datapath.
- No sub-module is needed. The read logic may optionally be factored into a small read-port mux module, gprf_read_port, instantiated twice, which returns 0 for index 0.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then release. Reading addresses 0..31 on both ports returns 0x00000000 everywhere.
- Basic write/read: write 0xDEADBEEF to reg 5 with write_enable=1. At 1 ns after the edge, address_A=5 gives reg_A=0xDEADBEEF. address_B=6 gives reg_B=0.
- Zero register: write 0x12345678 to reg 0. Afterwards, address_A=0 and address_B=0 both read 0x00000000.
- Write-enable gating: write 100 to reg 7. Then present address_W=7, write_data=999, write_enable=0. reg 7 still reads 100 after the edge.
- Dual port and overwrite:
  - Write reg 31 = 0xFFFFFFFF and reg 1 = 42. Reading A=31, B=1 gives 0xFFFFFFFF and 42.
  - Overwrite reg 1 = 43. Read A=1, B=1 before the edge: both 42. After the edge: both 43.
- Reset mid-operation: after writing reg 10 = 77, pulse rst low asynchronously between clock edges. reg 10 reads 0 immediately, and a write_enable asserted during reset has no effect.
